vedic_mul_arbiter: RTL

//  Shares one pipelined vedic multiplier among N requesters using round-robin arbitration.
//  The multiplier core (e.g. vedic4x4) has no valid, stall or reset of its own.

---
 rtl/vedic_mul_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/vedic_mul_arbiter.sv
// Round-robin front end for a shared, non-stallable pipelined multiplier core.
// Issues one operand pair per cycle and routes each product back to its requester via a tag pipe.
module vedic_mul_arbiter #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int LATENCY = 5,
  localparam int IDW    = $clog2(N),
  localparam int CW     = $clog2(LATENCY + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N-1:0]       req_valid,
  input  logic [N*W-1:0]     req_a,
  input  logic [N*W-1:0]     req_b,
  output logic [N-1:0]       req_ready,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [2*W-1:0]     mul_result,
  output logic [N-1:0]       rsp_valid,
  output logic [2*W-1:0]     rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy,
  output logic [CW-1:0]      inflight
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic           found;
  logic [N-1:0]   grant;
  logic           hs;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;

  // Tag pipe: stage s holds the op issued s edges ago; stage LATENCY lines up with mul_result.
  logic [LATENCY:0] tag_valid;
  logic [IDW-1:0]   tag_id [LATENCY+1];
  logic             retire;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_id = '0;
    cand     = '0;
    found    = 1'b0;
    grant    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(ptr) + k) % N);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
    if (en && !rst && found) grant[grant_id] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  assign req_ready = grant;
  assign hs        = |grant;
  assign retire    = tag_valid[LATENCY];
  assign busy      = (inflight != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= IDW'(N - 1);
      mul_a     <= '0;
      mul_b     <= '0;
      tag_valid <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      inflight  <= '0;
    end else begin
      if (hs) begin
        ptr   <= grant_id;
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
      tag_valid <= {tag_valid[LATENCY-1:0], hs};

      rsp_valid <= '0;
      if (retire) begin
        rsp_valid[tag_id[LATENCY]] <= 1'b1;
        rsp_data                   <= mul_result;
        rsp_id                     <= tag_id[LATENCY];
      end

      case ({hs, retire})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // NOTE: the id array is left unreset; only the valid bits decide whether a tag means anything.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int s = 1; s <= LATENCY; s++) tag_id[s] <= tag_id[s-1];
  end

endmodule
